// File: rtl/voice_allocator_if.sv
// Key/voice bundle between the key matrix side and the voice allocator.
// The allocator takes the raw keys and presents the per-voice note codes,
// the mixer load/select lines, the steal pulse and the debounced key levels.
interface voice_allocator_if #(
   parameter int NKEYS = 8
);
   logic [NKEYS-1:0] keys;
   logic [3:0]       note0;
   logic [3:0]       note1;
   logic [1:0]       ld;
   logic [1:0]       sel;
   logic             steal;
   logic [NKEYS-1:0] deb_keys;

   // Drives the keys and observes the allocator (testbench / front panel).
   modport master (
      output keys,
      input  note0, note1, ld, sel, steal, deb_keys
   );

   // The allocator itself.
   modport slave (
      input  keys,
      output note0, note1, ld, sel, steal, deb_keys
   );
endinterface

// File: rtl/voice_allocator.sv
// Two-voice key allocator: synchronizes and debounces NKEYS raw buttons,
// detects press/release edges, assigns pressed keys to the two tone voices
// in ascending key order, frees a voice on release and steals the oldest
// voice when both are busy.
module voice_allocator #(
   parameter int NKEYS      = 8,
   parameter int DEB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   voice_allocator_if.slave bus
);

   localparam int         CW      = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
   localparam logic [3:0] NO_NOTE = 4'hF;

   // Synchronizer and debounce state
   logic [NKEYS-1:0] sync1_q, sync1_d;
   logic [NKEYS-1:0] sync2_q, sync2_d;
   logic [CW-1:0]    cnt_q [NKEYS];
   logic [CW-1:0]    cnt_d [NKEYS];
   logic [NKEYS-1:0] deb_q, deb_d;
   logic [NKEYS-1:0] deb_dly_q, deb_dly_d;

   // Allocation state
   logic [3:0]       note_q [2];
   logic [3:0]       note_d [2];
   logic [1:0]       ld_q, ld_d;
   logic             oldest_q, oldest_d;
   logic             steal_q, steal_d;
   logic [NKEYS-1:0] pending_q, pending_d;

   // Per-cycle working values of the allocator
   logic [NKEYS-1:0] press;
   logic [1:0]       held;
   logic [NKEYS-1:0] sounding;
   logic [NKEYS-1:0] cand;
   logic [NKEYS-1:0] pick;
   logic [3:0]       k;

   // Two-flop synchronizer feeding the debouncers.
   always_comb begin
      sync1_d = bus.keys;
      sync2_d = sync1_q;
   end

   // Debounce: deb flips on the DEB_CYCLES-th consecutive differing sample.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      deb_d     = deb_q;
      cnt_d     = cnt_q;
      deb_dly_d = deb_q;
      for (int i = 0; i < NKEYS; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               deb_d[i] = ~deb_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Release, candidate selection and voice assignment for this cycle.
   always_comb begin
      note_d    = note_q;
      ld_d      = ld_q;
      oldest_d  = oldest_q;
      steal_d   = 1'b0;
      press     = deb_q & ~deb_dly_q;
      held      = '0;
      sounding  = '0;
      pick      = '0;
      k         = NO_NOTE;

      // Free any voice whose key is no longer held down.
      for (int v = 0; v < 2; v++) begin
         for (int i = 0; i < NKEYS; i++) begin
            if (note_q[v] == 4'(i)) held[v] = deb_q[i];
         end
         if (ld_q[v] && !held[v]) begin
            ld_d[v]   = 1'b0;
            note_d[v] = NO_NOTE;
         end
      end
      // One voice freed while the other keeps sounding: the survivor is oldest.
      if (ld_d != ld_q && ld_d != 2'b00) oldest_d = ld_d[1];

      // Keys already on a voice never compete for a second voice.
      for (int i = 0; i < NKEYS; i++) begin
         sounding[i] = (ld_d[0] && note_d[0] == 4'(i)) ||
                       (ld_d[1] && note_d[1] == 4'(i));
      end
      cand = (pending_q | press) & deb_q & ~sounding;

      // Lowest-index candidate wins; scanning downward leaves it last.
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (cand[i]) begin
            pick    = '0;
            pick[i] = 1'b1;
            k       = 4'(i);
         end
      end
      pending_d = cand & ~pick;

      if (|cand) begin
         if (!ld_d[0]) begin
            note_d[0] = k;
            ld_d[0]   = 1'b1;
            oldest_d  = ld_d[1];
         end else if (!ld_d[1]) begin
            note_d[1] = k;
            ld_d[1]   = 1'b1;
            oldest_d  = 1'b0;
         end else begin
            // Both busy: the oldest voice is taken over and the key it held stays unvoiced.
            note_d[oldest_d] = k;
            steal_d          = 1'b1;
            oldest_d         = ~oldest_d;
         end
      end
   end

   // State registers; asynchronous active-low reset clears everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         // NOTE: the per-key counter array is reset too, so a key bouncing across reset cannot inherit a partial count.
         cnt_q     <= '{default: '0};
         deb_q     <= '0;
         deb_dly_q <= '0;
         note_q    <= '{NO_NOTE, NO_NOTE};
         ld_q      <= '0;
         oldest_q  <= 1'b0;
         steal_q   <= 1'b0;
         pending_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         note_q    <= note_d;
         ld_q      <= ld_d;
         oldest_q  <= oldest_d;
         steal_q   <= steal_d;
         pending_q <= pending_d;
      end
   end

   assign bus.note0    = note_q[0];
   assign bus.note1    = note_q[1];
   assign bus.ld       = ld_q;
   assign bus.sel      = ld_q;
   assign bus.steal    = steal_q;
   assign bus.deb_keys = deb_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator (NKEYS=8, DEB_CYCLES=4). Stimulus pushes the
// expected output state and the cycle it must appear at into a scoreboard;
// a monitor pops an entry on every change of the voice outputs.
module tb_voice_allocator;

   localparam int NK  = 8;
   localparam int DEB = 4;

   typedef struct {
      int         cyc;
      logic [3:0] n0;
      logic [3:0] n1;
      logic [1:0] ld;
      logic       st;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;
   exp_t sb_q[$];

   voice_allocator_if #(.NKEYS(NK)) vif ();

   voice_allocator #(.NKEYS(NK), .DEB_CYCLES(DEB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input int c, input logic [3:0] n0, input logic [3:0] n1,
                             input logic [1:0] ld, input logic st, input string name);
      exp_t e;
      e.cyc = c; e.n0 = n0; e.n1 = n1; e.ld = ld; e.st = st; e.name = name;
      sb_q.push_back(e);
   endtask

   // Monitor: any change of {note0,note1,ld,steal} must match the next expectation.
   logic [10:0] prev = {4'hF, 4'hF, 2'b00, 1'b0};
   always @(negedge clk) begin
      logic [10:0] cur;
      exp_t        e;
      cur = {vif.note0, vif.note1, vif.ld, vif.steal};
      if (cur !== prev) begin
         if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_change: got 0x%0h, expected no change from 0x%0h (cycle %0d)",
                     cur, prev, cyc);
         end else begin
            e = sb_q.pop_front();
            check({e.name, " cycle"}, 32'(cyc), 32'(e.cyc));
            check({e.name, " outputs"}, 32'(cur), 32'({e.n0, e.n1, e.ld, e.st}));
            check({e.name, " sel"}, 32'(vif.sel), 32'(e.ld));
         end
         prev = cur;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      vif.keys = '0;
      #1 rst = 1'b0;
      tick(3);
      check("reset note0", 32'(vif.note0), 32'hF);
      check("reset note1", 32'(vif.note1), 32'hF);
      check("reset ld", 32'(vif.ld), 32'h0);
      check("reset sel", 32'(vif.sel), 32'h0);
      check("reset steal", 32'(vif.steal), 32'h0);
      check("reset deb_keys", 32'(vif.deb_keys), 32'h0);
      rst = 1'b1;
      tick(2);

      // 1: single key, press and release latency
      c = cyc; vif.keys = 8'h08;
      expect_out(c + 7, 4'd3, 4'hF, 2'b01, 1'b0, "t1 press3");
      tick(5);
      check("t1 deb before edge 6", 32'(vif.deb_keys), 32'h00);
      tick(1);
      check("t1 deb at edge 6", 32'(vif.deb_keys), 32'h08);
      tick(6);
      c = cyc; vif.keys = 8'h00;
      expect_out(c + 7, 4'hF, 4'hF, 2'b00, 1'b0, "t1 release3");
      tick(10);

      // 2: two voices, free and reuse
      c = cyc; vif.keys = 8'h04;
      expect_out(c + 7, 4'd2, 4'hF, 2'b01, 1'b0, "t2 press2");
      tick(10);
      c = cyc; vif.keys = 8'h24;
      expect_out(c + 7, 4'd2, 4'd5, 2'b11, 1'b0, "t2 press5");
      tick(10);
      c = cyc; vif.keys = 8'h20;
      expect_out(c + 7, 4'hF, 4'd5, 2'b10, 1'b0, "t2 release2");
      tick(10);
      c = cyc; vif.keys = 8'h60;
      expect_out(c + 7, 4'd6, 4'd5, 2'b11, 1'b0, "t2 press6");
      tick(10);
      c = cyc; vif.keys = 8'h00;
      expect_out(c + 7, 4'hF, 4'hF, 2'b00, 1'b0, "t2 release all");
      tick(10);

      // 3: steal the oldest voice twice
      c = cyc; vif.keys = 8'h02;
      expect_out(c + 7, 4'd1, 4'hF, 2'b01, 1'b0, "t3 press1");
      tick(10);
      c = cyc; vif.keys = 8'h12;
      expect_out(c + 7, 4'd1, 4'd4, 2'b11, 1'b0, "t3 press4");
      tick(10);
      c = cyc; vif.keys = 8'h92;
      expect_out(c + 7, 4'd7, 4'd4, 2'b11, 1'b1, "t3 steal v0");
      expect_out(c + 8, 4'd7, 4'd4, 2'b11, 1'b0, "t3 steal v0 end");
      tick(10);
      c = cyc; vif.keys = 8'h93;
      expect_out(c + 7, 4'd7, 4'd0, 2'b11, 1'b1, "t3 steal v1");
      expect_out(c + 8, 4'd7, 4'd0, 2'b11, 1'b0, "t3 steal v1 end");
      tick(10);
      c = cyc; vif.keys = 8'h00;
      expect_out(c + 7, 4'hF, 4'hF, 2'b00, 1'b0, "t3 release all");
      tick(10);

      // 4: simultaneous presses serviced one per cycle, ascending
      c = cyc; vif.keys = 8'h48;
      expect_out(c + 7, 4'd3, 4'hF, 2'b01, 1'b0, "t4 first key3");
      expect_out(c + 8, 4'd3, 4'd6, 2'b11, 1'b0, "t4 second key6");
      tick(12);
      c = cyc; vif.keys = 8'h00;
      expect_out(c + 7, 4'hF, 4'hF, 2'b00, 1'b0, "t4 release all");
      tick(10);

      // 5: 3-cycle bounce is filtered, then a stable press allocates normally
      for (int i = 0; i < 40; i++) begin
         vif.keys = (((i / 3) % 2) == 0) ? 8'h04 : 8'h00;
         tick(1);
         check("t5 bounce deb_keys", 32'(vif.deb_keys), 32'h00);
      end
      c = cyc; vif.keys = 8'h04;
      expect_out(c + 7, 4'd2, 4'hF, 2'b01, 1'b0, "t5 stable press2");
      tick(10);
      c = cyc; vif.keys = 8'h00;
      expect_out(c + 7, 4'hF, 4'hF, 2'b00, 1'b0, "t5 release2");
      tick(10);

      // 6: reset with both voices busy and key 2 pending
      c = cyc; vif.keys = 8'h07;
      expect_out(c + 7, 4'd0, 4'hF, 2'b01, 1'b0, "t6 press0");
      expect_out(c + 8, 4'd0, 4'd1, 2'b11, 1'b0, "t6 press1");
      tick(8);
      #6 rst = 1'b0;
      expect_out(c + 9, 4'hF, 4'hF, 2'b00, 1'b0, "t6 reset clear");
      #1;
      check("t6 rst note0", 32'(vif.note0), 32'hF);
      check("t6 rst note1", 32'(vif.note1), 32'hF);
      check("t6 rst ld", 32'(vif.ld), 32'h0);
      check("t6 rst deb_keys", 32'(vif.deb_keys), 32'h00);
      tick(3);
      rst = 1'b1;
      c = cyc;
      expect_out(c + 7, 4'd0, 4'hF, 2'b01, 1'b0, "t6 re-press0");
      expect_out(c + 8, 4'd0, 4'd1, 2'b11, 1'b0, "t6 re-press1");
      expect_out(c + 9, 4'd2, 4'd1, 2'b11, 1'b1, "t6 steal key2");
      expect_out(c + 10, 4'd2, 4'd1, 2'b11, 1'b0, "t6 steal end");
      tick(12);
      c = cyc; vif.keys = 8'h00;
      expect_out(c + 7, 4'hF, 4'hF, 2'b00, 1'b0, "t6 release all");
      tick(10);

      // Drain: every expectation must have been matched within the budget.
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
      while (sb_q.size() != 0) begin
         exp_t e;
         e = sb_q.pop_front();
         tests_run++;
         tests_failed++;
         $display("FAIL %s: no output change seen, expected at cycle %0d", e.name, e.cyc);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
